// File: rtl/ppi_bus_master.sv
// ppi_bus_master
//
// Bus initiator for an 8255-style PPI. Each accepted request becomes one
// bus cycle with three phases: setup, strobe and hold. The master then
// returns a one-cycle response pulse.
//
// A read of address 2'b11 is rejected because the control word is
// write-only. It produces an error response and generates no bus activity.
//
// State table:
//   state  | meaning
//   IDLE   | ready for a request; completion pulse is shown in the first IDLE cycle
//   SETUP  | cs low, address (and write data) stable, strobes high
//   STROBE | wrb or rdb low; read data captured on the edge that ends it
//   HOLD   | strobes high, cs/address/write data still held
//   ERR    | illegal read to 2'b11, no bus activity, error response follows
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-high reset
//   req_valid  request present
//   req_ready  master can accept a request this cycle
//   req_write  1 = write, 0 = read
//   req_addr   PPI register address {a1,a0}
//   req_wdata  write data
//   rsp_valid  one-cycle completion pulse
//   rsp_rdata  read data (8'hFF on error, unchanged on write)
//   rsp_err    illegal-request flag
//   cs         chip select, active low
//   a1, a0     register address
//   wrb, rdb   write / read strobes, active low
//   data       bidirectional PPI data bus

module ppi_bus_master #(
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 2,
    parameter int HOLD_CYC   = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [1:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_err,
    output logic       cs,
    output logic       a1,
    output logic       a0,
    output logic       wrb,
    output logic       rdb,
    inout  wire  [7:0] data
);

    // The phase counter is loaded with (length - 1) on phase entry.
    // The phase ends when the counter reads 0.
    localparam logic [7:0] SETUP_LD  = 8'(SETUP_CYC - 1);
    localparam logic [7:0] STROBE_LD = 8'(STROBE_CYC - 1);
    localparam logic [7:0] HOLD_LD   = 8'(HOLD_CYC - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        STROBE = 3'd2,
        HOLD   = 3'd3,
        ERR    = 3'd4
    } state_t;

    state_t     state, state_nx;
    logic [7:0] cnt, cnt_nx;
    logic       wr_q, wr_nx;
    logic [1:0] addr_q, addr_nx;
    logic [7:0] wdata_q, wdata_nx;
    logic       drive_en;

    logic       handshake;
    logic       bus_nx;
    logic       cs_nx, wrb_nx, rdb_nx, drive_nx, ready_nx;
    logic       rsp_valid_nx, rsp_err_nx;
    logic [7:0] rdata_nx;
    logic [1:0] a_nx;

    assign handshake = req_valid & req_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= 8'd0;
            wr_q    <= 1'b0;
            addr_q  <= 2'b00;
            wdata_q <= 8'h00;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            wr_q    <= wr_nx;
            addr_q  <= addr_nx;
            wdata_q <= wdata_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        wr_nx        = wr_q;
        addr_nx      = addr_q;
        wdata_nx     = wdata_q;
        rsp_valid_nx = 1'b0;
        rsp_err_nx   = 1'b0;
        rdata_nx     = rsp_rdata;

        case (state)
            IDLE: begin
                if (handshake) begin
                    wr_nx    = req_write;
                    addr_nx  = req_addr;
                    wdata_nx = req_wdata;
                    if (!req_write && req_addr == 2'b11) begin
                        state_nx = ERR;
                    end else begin
                        state_nx = SETUP;
                        cnt_nx   = SETUP_LD;
                    end
                end
            end
            SETUP: begin
                if (cnt == 8'd0) begin
                    state_nx = STROBE;
                    cnt_nx   = STROBE_LD;
                end else begin
                    cnt_nx = cnt - 8'd1;
                end
            end
            STROBE: begin
                if (cnt == 8'd0) begin
                    state_nx = HOLD;
                    cnt_nx   = HOLD_LD;
                    if (!wr_q) begin
                        rdata_nx = data;
                    end
                end else begin
                    cnt_nx = cnt - 8'd1;
                end
            end
            HOLD: begin
                if (cnt == 8'd0) begin
                    state_nx     = IDLE;
                    rsp_valid_nx = 1'b1;
                end else begin
                    cnt_nx = cnt - 8'd1;
                end
            end
            ERR: begin
                state_nx     = IDLE;
                rsp_valid_nx = 1'b1;
                rsp_err_nx   = 1'b1;
                rdata_nx     = 8'hFF;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        // Bus pins are registered from the next-state view.
        // As a result, every pin changes on the same edge as the phase.
        bus_nx   = (state_nx == SETUP) || (state_nx == STROBE) || (state_nx == HOLD);
        cs_nx    = !bus_nx;
        wrb_nx   = !((state_nx == STROBE) && wr_nx);
        rdb_nx   = !((state_nx == STROBE) && !wr_nx);
        drive_nx = bus_nx && wr_nx;
        ready_nx = (state_nx == IDLE);
        a_nx     = bus_nx ? addr_nx : {a1, a0};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= 8'h00;
            cs        <= 1'b1;
            wrb       <= 1'b1;
            rdb       <= 1'b1;
            a1        <= 1'b0;
            a0        <= 1'b0;
            drive_en  <= 1'b0;
        end else begin
            req_ready <= ready_nx;
            rsp_valid <= rsp_valid_nx;
            rsp_err   <= rsp_err_nx;
            rsp_rdata <= rdata_nx;
            cs        <= cs_nx;
            wrb       <= wrb_nx;
            rdb       <= rdb_nx;
            a1        <= a_nx[1];
            a0        <= a_nx[0];
            drive_en  <= drive_nx;
        end
    end

    assign data = drive_en ? wdata_q : 8'hzz;

endmodule
